// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter sharing the instruction-memory port between fetch and loader.
// Define IMEM_LOADER_PRIORITY_EN to make the loader win every contention.
module imem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset0,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [DW-1:0] f_rdata,
    output logic          f_err,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_ack,
    output logic [DW-1:0] l_rdata,
    output logic          l_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_we,
    input  logic [DW-1:0] mem_outp,
    input  logic          mem_valid,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state, state_nx;
    logic   last_l;
    logic   win_l;
    logic   pick_l;

    always_comb begin
        state_nx = state;
        pick_l   = l_req;
        if (f_req && l_req) begin
`ifdef IMEM_LOADER_PRIORITY_EN
            pick_l = 1'b1;
`else
            pick_l = !last_l;
`endif
        end
        unique case (state)
            IDLE:    if (f_req || l_req) state_nx = ACCESS;
            ACCESS:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // last_l resets to 1 so fetch wins the first tie.
    always_ff @(posedge clock or negedge reset0) begin
        if (!reset0) begin
            state    <= IDLE;
            last_l   <= 1'b1;
            win_l    <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
            f_ack    <= 1'b0;
            f_rdata  <= '0;
            f_err    <= 1'b0;
            l_ack    <= 1'b0;
            l_rdata  <= '0;
            l_err    <= 1'b0;
        end else begin
            state <= state_nx;
            f_ack <= 1'b0;
            l_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (f_req || l_req) begin
                        mem_addr <= pick_l ? l_addr : f_addr;
                        mem_data <= pick_l ? l_wdata : '0;
                        mem_we   <= pick_l && l_we && (l_addr[1:0] == 2'b00);
                        last_l   <= pick_l;
                        win_l    <= pick_l;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    if (win_l) begin
                        l_ack   <= 1'b1;
                        l_rdata <= mem_valid ? mem_outp : '0;
                        l_err   <= !mem_valid;
                    end else begin
                        f_ack   <= 1'b1;
                        f_rdata <= mem_valid ? mem_outp : '0;
                        f_err   <= !mem_valid;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed scoreboard bench for imem_port_arbiter with a behavioural memory.
module tb_imem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset0;
    logic        f_req, l_req, l_we;
    logic [31:0] f_addr, l_addr, l_wdata;
    logic        f_ack, f_err, l_ack, l_err, mem_we, busy;
    logic [31:0] f_rdata, l_rdata, mem_addr, mem_data, mem_outp;
    logic        mem_valid;

    logic [31:0] mem [0:63];
    logic [31:0] model [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_val;

    typedef struct packed {
        logic        is_f;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    int total = 0;
    int bad = 0;

    imem_port_arbiter dut (
        .clock(clock), .reset0(reset0),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
        .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_ack(l_ack), .l_rdata(l_rdata), .l_err(l_err),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .mem_outp(mem_outp), .mem_valid(mem_valid), .busy(busy)
    );

    always #5 clock = ~clock;

    // Write-through memory: a write shows its data on the read port.
    assign mem_valid = (mem_addr[1:0] == 2'b00);
    assign mem_outp  = mem_we ? mem_data : mem[mem_addr[7:2]];

    always @(posedge clock) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_data;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (f_ack || l_ack) begin
            check("ack_excl", {31'd0, f_ack & l_ack}, 32'd0);
            if (sbq.size() == 0) begin
                check("sb_unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("ack_who", {31'd0, f_ack}, {31'd0, e.is_f});
                if (e.is_f) begin
                    check("f_rdata", f_rdata, e.rdata);
                    check("f_err", {31'd0, f_err}, {31'd0, e.err});
                end else begin
                    check("l_rdata", l_rdata, e.rdata);
                    check("l_err", {31'd0, l_err}, {31'd0, e.err});
                end
            end
        end
        if (mem_we) check("we_align", {30'd0, mem_addr[1:0]}, 32'd0);
    end

    task automatic preload(input int idx, input logic [31:0] val);
        pre_we = 1'b1;
        pre_idx = idx[5:0];
        pre_val = val;
        model[idx] = val;
        @(posedge clock);
        #1 pre_we = 1'b0;
    endtask

    function automatic exp_t expect_of(input bit is_f, input bit we,
                                       input logic [31:0] addr,
                                       input logic [31:0] wdata);
        exp_t e;
        e.is_f = is_f;
        if (addr[1:0] != 2'b00) begin
            e.rdata = 32'd0;
            e.err = 1'b1;
        end else if (!is_f && we) begin
            e.rdata = wdata;
            e.err = 1'b0;
            model[addr[7:2]] = wdata;
        end else begin
            e.rdata = model[addr[7:2]];
            e.err = 1'b0;
        end
        return e;
    endfunction

    // Called #1 after an edge with the arbiter idle.
    task automatic txn(input bit is_f, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata);
        sbq.push_back(expect_of(is_f, we, addr, wdata));
        if (is_f) begin
            f_req = 1'b1; f_addr = addr;
        end else begin
            l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata;
        end
        @(posedge clock); #1;
        check("grant_busy", {31'd0, busy}, 32'd1);
        check("grant_addr", mem_addr, addr);
        check("grant_we", {31'd0, mem_we},
              {31'd0, !is_f && we && addr[1:0] == 2'b00});
        check("grant_noack", {30'd0, f_ack, l_ack}, 32'd0);
        @(posedge clock); #1;
        check("ack_latency", {31'd0, is_f ? f_ack : l_ack}, 32'd1);
        f_req = 1'b0;
        l_req = 1'b0;
        @(posedge clock); #1;
        check("idle_again", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset0 = 1'b0;
        f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
        f_addr = '0; l_addr = '0; l_wdata = '0;
        pre_we = 1'b0; pre_idx = '0; pre_val = '0;
        for (int i = 0; i < 64; i++) model[i] = 32'd0;
        preload(0, 32'd0);
        preload(4, 32'hDEADBEEF);
        preload(8, 32'h0BADF00D);
        preload(12, 32'h5A5A5A5A);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_acks", {30'd0, f_ack, l_ack}, 32'd0);
        check("rst_errs", {30'd0, f_err, l_err}, 32'd0);
        check("rst_frd", f_rdata, 32'd0);
        check("rst_lrd", l_rdata, 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_mdata", mem_data, 32'd0);
        @(negedge clock) reset0 = 1'b1;
        @(posedge clock); #1;

        txn(1'b1, 1'b0, 32'h10, 32'h0);
        txn(1'b0, 1'b1, 32'h20, 32'h12345678);
        txn(1'b1, 1'b0, 32'h20, 32'h0);
        txn(1'b0, 1'b1, 32'h22, 32'hAAAA5555);
        txn(1'b1, 1'b0, 32'h13, 32'h0);
        txn(1'b0, 1'b0, 32'h20, 32'h0);

        // Contention; the previous grant went to the loader.
`ifdef IMEM_LOADER_PRIORITY_EN
        for (int i = 0; i < 4; i++)
            sbq.push_back(expect_of(1'b0, 1'b0, 32'h20, 32'h0));
`else
        for (int i = 0; i < 2; i++) begin
            sbq.push_back(expect_of(1'b1, 1'b0, 32'h10, 32'h0));
            sbq.push_back(expect_of(1'b0, 1'b0, 32'h20, 32'h0));
        end
`endif
        f_req = 1'b1; f_addr = 32'h10;
        l_req = 1'b1; l_we = 1'b0; l_addr = 32'h20;
        repeat (12) @(posedge clock);
        #1;
        f_req = 1'b0; l_req = 1'b0;
        repeat (3) @(posedge clock);
        #1;
`ifdef IMEM_LOADER_PRIORITY_EN
        check("contend_drain", sbq.size(), 32'd0);
`else
        check("contend_drain", sbq.size(), 32'd0);
`endif

        // Reset in the middle of a loader write access.
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h30; l_wdata = 32'hCAFEF00D;
        @(posedge clock); #1;
        check("abort_we_pre", {31'd0, mem_we}, 32'd1);
        reset0 = 1'b0;
        #1;
        check("abort_we", {31'd0, mem_we}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        l_req = 1'b0; l_we = 1'b0;
        @(posedge clock);
        @(negedge clock) reset0 = 1'b1;
        @(posedge clock); #1;
        txn(1'b1, 1'b0, 32'h30, 32'h0);
        txn(1'b1, 1'b0, 32'h10, 32'h0);

        repeat (2) @(posedge clock);
        check("sb_drain", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
